elevator_request_scheduler: RTL

Collects hall and car calls, holds them in a pending-request register, and dispatches one target floor at a time to elevator_controller using SCAN (collective) ordering. Sits between the floor/car button inputs and elevator_controller; drives its request_floor input and consumes its complete, door_alert and weigh_alert outputs. Floors are one-hot: bit0 = floor 0 (lowest), bit3 = top floor.

---
 rtl/elevator_pkg.sv | 40 ++++
 rtl/elevator_scan_select.sv | 82 ++++++++
 rtl/elevator_request_scheduler.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/elevator_pkg.sv
// Shared types and helpers for the elevator request scheduler.
// Latency: none (types, constants and pure functions only).
// Backpressure: not applicable.
package elevator_pkg;

    localparam int NUM_FLOORS_DEF = 4;
    // Width used by the floor/index helpers; callers zero-extend narrower vectors.
    localparam int MAX_FLOORS     = 32;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        SELECT    = 3'd1,
        WAIT_DONE = 3'd2,
        DWELL     = 3'd3,
        HOLD      = 3'd4
    } sched_state_t;

    // Index of the lowest set bit; 0 when the vector is empty.
    function automatic int onehot_to_idx(input logic [MAX_FLOORS-1:0] vec);
        int idx;
        idx = 0;
        for (int i = MAX_FLOORS - 1; i >= 0; i--) begin
            if (vec[i]) begin
                idx = i;
            end
        end
        return idx;
    endfunction

    function automatic logic [MAX_FLOORS-1:0] idx_to_onehot(input int idx);
        logic [MAX_FLOORS-1:0] vec;
        vec    = '0;
        vec[0] = 1'b1;
        return vec << idx;
    endfunction

endpackage

// File: rtl/elevator_scan_select.sv
// SCAN picker: nearest pending floor beyond last_floor in sched_dir, else reverse, else last_floor.
// Latency: purely combinational.
// Backpressure: none; the caller decides when to sample the result.
module elevator_scan_select
    import elevator_pkg::*;
#(
    parameter int NUM_FLOORS = NUM_FLOORS_DEF
) (
    input  logic [NUM_FLOORS-1:0] pending,
    input  logic [NUM_FLOORS-1:0] last_floor,
    input  logic                  sched_dir,
    output logic [NUM_FLOORS-1:0] next_target,
    output logic                  next_dir,
    output logic                  target_vld
);

    logic [MAX_FLOORS-1:0] last_wide;
    logic [MAX_FLOORS-1:0] pick_wide;
    int                    cur_idx;
    int                    above_idx;
    int                    below_idx;
    int                    pick_idx;
    logic                  above_found;
    logic                  below_found;
    logic                  here_found;

    // Find the nearest pending floor on each side of the car, then apply SCAN priority.
    always_comb begin
        last_wide                  = '0;
        last_wide[NUM_FLOORS-1:0]  = last_floor;
        cur_idx                    = onehot_to_idx(last_wide);

        // Descending scan leaves the lowest floor strictly above the car.
        above_found = 1'b0;
        above_idx   = 0;
        for (int i = NUM_FLOORS - 1; i >= 0; i--) begin
            if (pending[i] && (i > cur_idx)) begin
                above_found = 1'b1;
                above_idx   = i;
            end
        end

        // Ascending scan leaves the highest floor strictly below the car.
        below_found = 1'b0;
        below_idx   = 0;
        for (int i = 0; i < NUM_FLOORS; i++) begin
            if (pending[i] && (i < cur_idx)) begin
                below_found = 1'b1;
                below_idx   = i;
            end
        end

        here_found = |(pending & last_floor);

        pick_idx   = cur_idx;
        next_dir   = sched_dir;
        target_vld = 1'b1;
        if (sched_dir == DIR_UP) begin
            if (above_found) begin
                pick_idx = above_idx;
            end else if (below_found) begin
                pick_idx = below_idx;
                next_dir = DIR_DOWN;
            end else if (!here_found) begin
                target_vld = 1'b0;
            end
        end else begin
            if (below_found) begin
                pick_idx = below_idx;
            end else if (above_found) begin
                pick_idx = above_idx;
                next_dir = DIR_UP;
            end else if (!here_found) begin
                target_vld = 1'b0;
            end
        end

        pick_wide   = idx_to_onehot(pick_idx);
        next_target = pick_wide[NUM_FLOORS-1:0];
    end

endmodule

// File: rtl/elevator_request_scheduler.sv
// Collects hall/car calls and dispatches one SCAN-ordered target floor at a time; optional SCHED_WATCHDOG_EN.
// Latency: call in IDLE -> req_valid 3 cycles later; DWELL lasts DWELL_CYCLES after each completed stop.
// Backpressure: request_floor/req_valid held until complete or alert; calls are sticky in pending, never dropped.
module elevator_request_scheduler
    import elevator_pkg::*;
#(
    parameter int NUM_FLOORS     = NUM_FLOORS_DEF,
    parameter int DWELL_CYCLES   = 4,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_FLOORS-1:0] hall_call,
    input  logic [NUM_FLOORS-1:0] car_call,
    input  logic [NUM_FLOORS-1:0] in_current_floor,
    input  logic                  complete,
    input  logic                  door_alert,
    input  logic                  weigh_alert,
    output logic [NUM_FLOORS-1:0] request_floor,
    output logic                  req_valid,
    output logic [NUM_FLOORS-1:0] pending,
    output logic                  sched_dir,
    output logic                  busy,
    output logic                  fault
);

    localparam int                    DW_W         = $clog2(DWELL_CYCLES + 1);
    localparam logic [DW_W-1:0]       DWELL_LAST   = DW_W'(DWELL_CYCLES - 1);
    localparam logic [NUM_FLOORS-1:0] FLOOR_BOTTOM = NUM_FLOORS'(1);

    if (DWELL_CYCLES < 1 || TIMEOUT_CYCLES < 1) begin : g_bad_params
        $error("elevator_request_scheduler: DWELL_CYCLES and TIMEOUT_CYCLES must be >= 1");
    end

    sched_state_t          state;
    sched_state_t          state_next;
    logic [NUM_FLOORS-1:0] last_floor;
    logic [DW_W-1:0]       dwell_cnt;
    logic                  alert;
    logic                  load_target;
    logic                  serve_done;
    logic                  drop_valid;
    logic                  dwell_reload;
    logic                  dwell_expire;
    logic                  wd_expire;
    logic [NUM_FLOORS-1:0] sel_target;
    logic                  sel_dir;
    logic                  sel_vld;

    assign alert = door_alert | weigh_alert;
    assign busy  = (state != IDLE);

    elevator_scan_select #(
        .NUM_FLOORS (NUM_FLOORS)
    ) u_scan_select (
        .pending     (pending),
        .last_floor  (last_floor),
        .sched_dir   (sched_dir),
        .next_target (sel_target),
        .next_dir    (sel_dir),
        .target_vld  (sel_vld)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and per-cycle control strobes.
    always_comb begin
        state_next   = state;
        load_target  = 1'b0;
        serve_done   = 1'b0;
        drop_valid   = 1'b0;
        dwell_reload = 1'b0;
        dwell_expire = 1'b0;
        case (state)
            IDLE: begin
                if (pending != '0) begin
                    state_next = SELECT;
                end
            end
            SELECT: begin
                load_target = 1'b1;
                state_next  = sel_vld ? WAIT_DONE : IDLE;
            end
            WAIT_DONE: begin
                // complete beats an alert in the same cycle; the watchdog is lowest priority.
                if (complete) begin
                    serve_done = 1'b1;
                    drop_valid = 1'b1;
                    state_next = DWELL;
                end else if (alert) begin
                    drop_valid = 1'b1;
                    state_next = HOLD;
                end else if (wd_expire) begin
                    drop_valid = 1'b1;
                    state_next = SELECT;
                end
            end
            DWELL: begin
                if (alert) begin
                    dwell_reload = 1'b1;
                end else if (dwell_cnt == DWELL_LAST) begin
                    dwell_expire = 1'b1;
                    state_next   = (pending != '0) ? SELECT : IDLE;
                end
            end
            HOLD: begin
                if (!alert) begin
                    state_next = SELECT;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Track the last valid one-hot position; glitchy controller values are ignored.
    always_ff @(posedge clk) begin
        if (!reset) begin
            last_floor <= FLOOR_BOTTOM;
        end else if ($onehot(in_current_floor)) begin
            last_floor <= in_current_floor;
        end
    end

    // Sticky call capture; clearing the served floor overrides a same-cycle new call on it.
    always_ff @(posedge clk) begin
        if (!reset) begin
            pending <= '0;
        end else begin
            pending <= (pending | hall_call | car_call) & ~(serve_done ? request_floor : '0);
        end
    end

    // Dispatch registers: target, valid and travel direction.
    always_ff @(posedge clk) begin
        if (!reset) begin
            request_floor <= '0;
            req_valid     <= 1'b0;
            sched_dir     <= DIR_UP;
        end else if (load_target && sel_vld) begin
            request_floor <= sel_target;
            req_valid     <= 1'b1;
            sched_dir     <= sel_dir;
        end else if (drop_valid) begin
            req_valid     <= 1'b0;
        end
    end

    // Door dwell counter; restarts whenever an alert is seen.
    always_ff @(posedge clk) begin
        if (!reset) begin
            dwell_cnt <= '0;
        end else if ((state == DWELL) && !dwell_reload && !dwell_expire) begin
            dwell_cnt <= dwell_cnt + 1'b1;
        end else begin
            dwell_cnt <= '0;
        end
    end

`ifdef SCHED_WATCHDOG_EN
    localparam int              WD_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

    logic [WD_W-1:0] wd_cnt;
    logic            fault_q;

    assign wd_expire = (state == WAIT_DONE) && !complete && !alert && (wd_cnt == WD_LAST);
    assign fault     = fault_q;

    // Watchdog: counts cycles spent waiting for complete, cleared on any exit.
    always_ff @(posedge clk) begin
        if (!reset) begin
            wd_cnt  <= '0;
            fault_q <= 1'b0;
        end else begin
            fault_q <= wd_expire;
            if ((state == WAIT_DONE) && (state_next == WAIT_DONE)) begin
                wd_cnt <= wd_cnt + 1'b1;
            end else begin
                wd_cnt <= '0;
            end
        end
    end
`else
    assign wd_expire = 1'b0;
    assign fault     = 1'b0;
`endif

endmodule
